pipeline_ctrl: RTL and testbench

PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

---
 rtl/pipeline_ctrl.sv | 147 ++++++++++++++
 tb/tb_pipeline_ctrl.sv | 135 +++++++++++++
 2 files changed

// File: rtl/pipeline_ctrl.sv
// Pipeline stall/flush controller: turns load-use and jump hazard requests into
// pipeline register enables, NOP flushes and one-cycle completion acknowledges.
module pipeline_ctrl #(
    parameter int LU_STALL_CYCLES = 1,
    parameter int JU_FLUSH_CYCLES = 1
) (
    input  logic CLK,
    input  logic nRST,
    input  logic ihit,
    input  logic dmem_req,
    input  logic dhit,
    input  logic halt,
    input  logic load_use,
    input  logic flag_lu,
    input  logic jump_use,
    input  logic flag_ju,
    output logic pc_en,
    output logic ifid_en,
    output logic idex_en,
    output logic exmem_en,
    output logic memwb_en,
    output logic ifid_flush,
    output logic idex_flush,
    output logic flag_lu_done,
    output logic flag_ju_done,
    output logic halted
);

    typedef enum logic [1:0] {IDLE, LU_STALL, JU_FLUSH, HALTED} state_t;

    localparam logic [1:0] LU_LOAD = 2'(LU_STALL_CYCLES - 1);
    localparam logic [1:0] JU_LOAD = 2'(JU_FLUSH_CYCLES - 1);

    state_t     state;
    logic [1:0] cnt;
    logic       adv;
    logic       lu_req;
    logic       ju_req;

    assign adv = ihit & (~dmem_req | dhit);

    // A request is ignored while its own acknowledge is on the wire, so the
    // hazard unit gets one cycle to drop the pending flag.
    assign lu_req = load_use & flag_lu & ~flag_lu_done;
    assign ju_req = jump_use & flag_ju & ~flag_ju_done;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state        <= IDLE;
            cnt          <= 2'd0;
            flag_lu_done <= 1'b0;
            flag_ju_done <= 1'b0;
        end else begin
            flag_lu_done <= 1'b0;
            flag_ju_done <= 1'b0;
            if (halt) begin
                state <= HALTED;
            end else if (adv) begin
                case (state)
                    IDLE: begin
                        if (lu_req) begin
                            if (LU_STALL_CYCLES <= 1) begin
                                flag_lu_done <= 1'b1;
                            end else begin
                                state <= LU_STALL;
                                cnt   <= LU_LOAD;
                            end
                        end else if (ju_req) begin
                            if (JU_FLUSH_CYCLES <= 1) begin
                                flag_ju_done <= 1'b1;
                            end else begin
                                state <= JU_FLUSH;
                                cnt   <= JU_LOAD;
                            end
                        end
                    end
                    // cnt counts the stall cycles still owed after this one
                    LU_STALL: begin
                        if (cnt <= 2'd1) begin
                            state        <= IDLE;
                            cnt          <= 2'd0;
                            flag_lu_done <= 1'b1;
                        end else begin
                            cnt <= cnt - 2'd1;
                        end
                    end
                    JU_FLUSH: begin
                        if (cnt <= 2'd1) begin
                            state        <= IDLE;
                            cnt          <= 2'd0;
                            flag_ju_done <= 1'b1;
                        end else begin
                            cnt <= cnt - 2'd1;
                        end
                    end
                    default: state <= HALTED;
                endcase
            end
        end
    end

    always_comb begin
        pc_en      = 1'b0;
        ifid_en    = 1'b0;
        idex_en    = 1'b0;
        exmem_en   = 1'b0;
        memwb_en   = 1'b0;
        ifid_flush = 1'b0;
        idex_flush = 1'b0;
        if (nRST && adv) begin
            case (state)
                IDLE: begin
                    pc_en    = 1'b1;
                    ifid_en  = 1'b1;
                    idex_en  = 1'b1;
                    exmem_en = 1'b1;
                    memwb_en = 1'b1;
                    if (lu_req) begin
                        pc_en      = 1'b0;
                        ifid_en    = 1'b0;
                        idex_flush = 1'b1;
                    end else if (ju_req) begin
                        ifid_flush = 1'b1;
                    end
                end
                LU_STALL: begin
                    idex_en    = 1'b1;
                    exmem_en   = 1'b1;
                    memwb_en   = 1'b1;
                    idex_flush = 1'b1;
                end
                JU_FLUSH: begin
                    pc_en      = 1'b1;
                    ifid_en    = 1'b1;
                    idex_en    = 1'b1;
                    exmem_en   = 1'b1;
                    memwb_en   = 1'b1;
                    ifid_flush = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign halted = (state == HALTED);

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Scoreboard bench for pipeline_ctrl (LU_STALL_CYCLES=2, JU_FLUSH_CYCLES=1):
// stimulus pushes hand-computed per-cycle outputs, a negedge monitor pops and compares.
module tb_pipeline_ctrl;

    logic CLK = 1'b0;
    logic nRST = 1'b0;
    logic ihit = 1'b0, dmem_req = 1'b0, dhit = 1'b0, halt = 1'b0;
    logic load_use = 1'b0, flag_lu = 1'b0, jump_use = 1'b0, flag_ju = 1'b0;
    logic pc_en, ifid_en, idex_en, exmem_en, memwb_en;
    logic ifid_flush, idex_flush, flag_lu_done, flag_ju_done, halted;

    int passCount = 0;
    int checkCount = 0;

    logic [9:0] expQ[$];
    string      nameQ[$];

    // {pc,ifid,idex,exmem,memwb, ifid_flush,idex_flush, lu_done,ju_done, halted}
    localparam logic [9:0] ZERO  = 10'b00000_00_00_0;
    localparam logic [9:0] NORM  = 10'b11111_00_00_0;
    localparam logic [9:0] LUST  = 10'b00111_01_00_0;
    localparam logic [9:0] JUFL  = 10'b11111_10_00_0;
    localparam logic [9:0] LUD   = 10'b00000_00_10_0;
    localparam logic [9:0] JUD   = 10'b00000_00_01_0;
    localparam logic [9:0] HALTV = 10'b00000_00_00_1;

    pipeline_ctrl #(
        .LU_STALL_CYCLES(2),
        .JU_FLUSH_CYCLES(1)
    ) dut (
        .CLK(CLK),
        .nRST(nRST),
        .ihit(ihit),
        .dmem_req(dmem_req),
        .dhit(dhit),
        .halt(halt),
        .load_use(load_use),
        .flag_lu(flag_lu),
        .jump_use(jump_use),
        .flag_ju(flag_ju),
        .pc_en(pc_en),
        .ifid_en(ifid_en),
        .idex_en(idex_en),
        .exmem_en(exmem_en),
        .memwb_en(memwb_en),
        .ifid_flush(ifid_flush),
        .idex_flush(idex_flush),
        .flag_lu_done(flag_lu_done),
        .flag_ju_done(flag_ju_done),
        .halted(halted)
    );

    always #5 CLK = ~CLK;

    // Drive one cycle of inputs just after the rising edge and queue its expected outputs.
    // vec = {nRST, ihit, dmem_req, dhit, halt, load_use, flag_lu, jump_use, flag_ju}
    task automatic applyStimulus(input string name, input logic [8:0] vec, input logic [9:0] expected);
        @(posedge CLK);
        #1;
        {nRST, ihit, dmem_req, dhit, halt, load_use, flag_lu, jump_use, flag_ju} = vec;
        expQ.push_back(expected);
        nameQ.push_back(name);
    endtask

    task automatic checkOutput(input string name, input logic [9:0] expected);
        logic [9:0] actual;
        actual = {pc_en, ifid_en, idex_en, exmem_en, memwb_en,
                  ifid_flush, idex_flush, flag_lu_done, flag_ju_done, halted};
        checkCount++;
        if (actual === expected)
            passCount++;
        else
            $display("[TB] FAIL %s: outputs=%b expected=%b", name, actual, expected);
    endtask

    // Monitor: compares whatever the DUT presents against the oldest queued expectation.
    always @(negedge CLK) begin
        if (expQ.size() > 0) begin
            checkOutput(nameQ.pop_front(), expQ.pop_front());
        end
    end

    initial begin
        applyStimulus("reset_holds_zero",  9'b0_1000_0000, ZERO);
        applyStimulus("idle_adv",          9'b1_1000_0000, NORM);
        applyStimulus("idle_no_ihit",      9'b1_0000_0000, ZERO);
        applyStimulus("idle_dmem_wait",    9'b1_1100_0000, ZERO);
        applyStimulus("idle_dmem_hit",     9'b1_1110_0000, NORM);
        applyStimulus("lu_without_flag",   9'b1_1000_1000, NORM);

        applyStimulus("lu2_cycle0",        9'b1_1000_1100, LUST);
        applyStimulus("lu2_cycle1_nflag",  9'b1_1000_0000, LUST);
        applyStimulus("lu2_cycle2_done",   9'b1_1000_0000, NORM | LUD);
        applyStimulus("lu2_after",         9'b1_1000_0000, NORM);

        applyStimulus("ju1_flush",         9'b1_1000_0011, JUFL);
        applyStimulus("ju1_done_nodetect", 9'b1_1000_0011, NORM | JUD);
        applyStimulus("ju1_after",         9'b1_1000_0000, NORM);

        applyStimulus("both_cycle0",       9'b1_1000_1111, LUST);
        applyStimulus("both_cycle1",       9'b1_1000_1111, LUST);
        applyStimulus("both_lu_done_ju",   9'b1_1000_1111, JUFL | LUD);
        applyStimulus("both_ju_done",      9'b1_1000_0000, NORM | JUD);
        applyStimulus("both_after",        9'b1_1000_0000, NORM);

        applyStimulus("lu_dwait_detect",   9'b1_1000_1100, LUST);
        applyStimulus("lu_dwait_1",        9'b1_1100_0000, ZERO);
        applyStimulus("lu_dwait_2",        9'b1_1100_0000, ZERO);
        applyStimulus("lu_dwait_3",        9'b1_1100_0000, ZERO);
        applyStimulus("lu_dwait_resume",   9'b1_1110_0000, LUST);
        applyStimulus("lu_dwait_done",     9'b1_1000_0000, NORM | LUD);

        applyStimulus("halt_with_jump",    9'b1_1001_0011, JUFL);
        applyStimulus("halted_1",          9'b1_1000_0000, HALTV);
        applyStimulus("halted_2",          9'b1_1000_0011, HALTV);
        applyStimulus("halted_reset",      9'b0_1000_0000, ZERO);
        applyStimulus("halt_release",      9'b1_1000_0000, NORM);

        applyStimulus("rst_lu_detect",     9'b1_1000_1100, LUST);
        applyStimulus("rst_mid_stall",     9'b0_1000_0000, ZERO);
        applyStimulus("rst_release",       9'b1_1000_0000, NORM);
        applyStimulus("rst_no_done",       9'b1_1000_0000, NORM);
        applyStimulus("rst_release_noih",  9'b1_0000_0000, ZERO);

        for (int i = 0; i < 10 && expQ.size() > 0; i++) @(posedge CLK);
        @(posedge CLK);
        if (expQ.size() > 0) begin
            checkCount++;
            $display("[TB] FAIL drain: pending=%0d expected=0", expQ.size());
        end
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
